mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares a single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). It sits between fetch/memory and the memory macro. The data port normally has priority, and a streak counter bounds instruction starvation. Byte-enables and aligned write data are generated for sub-word stores, and misaligned data accesses are rejected with an error instead of being issued.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory side
- MAX_DATA_STREAK, 4, maximum consecutive data grants while if_req is pending; range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch word address; bits [1:0] are ignored
- if_ack  out  1  one-cycle pulse; if_rdata is valid this cycle
- if_rdata  out  32  instruction word
- d_req  in  1  data request; held with its qualifiers stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_len  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal
- d_addr  in  ADDR_W  byte address
- d_wdata  in  32  store data, right-aligned
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  valid with d_ack; misaligned or illegal size
- d_rdata  out  32  raw memory word; valid with d_ack on loads
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted write data
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_done  in  1  access complete; mem_rdata valid
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D, ERR_D.
- Arbitration happens in IDLE only and is combinational from the current inputs.
  - Grant D if d_req, unless if_req && streak == MAX_DATA_STREAK.
  - Otherwise grant I if if_req.
- Granted D with a legal access: mem_req = 1, mem_we = d_we, mem_addr = {d_addr[ADDR_W-1:2], 2'b00}.
  - Byte: mem_be = 0001 << d_addr[1:0]; mem_wdata = {4{d_wdata[7:0]}}.
  - Half: mem_be = 0011 << d_addr[1:0]; mem_wdata = {2{d_wdata[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = d_wdata.
  - On a load, mem_be follows the same rule.
- Granted D with an illegal access: d_len == 11, half with d_addr[0] = 1, or word with d_addr[1:0] != 0.
  - No mem_req is issued; the FSM goes to ERR_D.
- Granted I: mem_req = 1, mem_we = 0, mem_be = 1111, mem_addr = {if_addr[ADDR_W-1:2], 2'b00}.
- IDLE → WAIT_I / WAIT_D only when mem_ready = 1 in the same cycle. If mem_ready = 0, stay in IDLE and re-arbitrate next cycle.
- WAIT_x: mem_req = 0.
  - On mem_done: x_ack = 1, x_rdata = mem_rdata (combinational pass-through), next state IDLE.
  - d_err = 0 on this completion.
- ERR_D: d_ack = 1, d_err = 1, d_rdata = 0; next state IDLE.
- Streak counter (4 bits):
  - +1 on each D grant (IDLE→WAIT_D or IDLE→ERR_D) while if_req = 1.
  - Cleared on an I grant, or in any cycle with if_req = 0.
  - Saturates at MAX_DATA_STREAK.
- mem_done is ignored in IDLE and ERR_D.
- A requester whose req is still high in the cycle after its ack is making a new request.
- Outputs not listed for a state are 0.

## Timing
- Reset values: state IDLE, streak 0; all outputs 0 (mem_addr, mem_wdata, rdata buses = 0).
- Minimum memory access: grant + accept at cycle N; mem_done at N+1 gives ack at N+1; next arbitration at N+2.
- Latency formula: ack occurs in the mem_done cycle. Throughput is at most one access per 2 cycles.
- Misaligned access: detected at cycle N, d_ack/d_err at N+1, no memory traffic.
- Simultaneous if_req and d_req in IDLE: D wins unless streak == MAX_DATA_STREAK.
- rst asserted mid-transaction: next cycle is IDLE with no ack. A later stale mem_done is ignored. The requester re-issues.
- if_req / d_req dropping during WAIT_x: the transaction still completes and ack still pulses. Requesters must not do this.

## Test plan
- Single word load: d_req, d_addr = 0x104, d_len = 10; memory ready at once, done next cycle with 0xDEADBEEF.
  - Expect mem_addr = 0x104, mem_be = 1111, then d_ack with d_rdata = 0xDEADBEEF and d_err = 0.
- Byte store: d_addr = 0x203, d_len = 00, d_wdata = 0x000000A5.
  - Expect mem_addr = 0x200, mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_we = 1.
- Misaligned half: d_addr = 0x101, d_len = 01.
  - Expect no mem_req; d_ack with d_err = 1 next cycle.
- Contention: if_req and d_req held continuously, MAX_DATA_STREAK = 4.
  - Expect grant order D, D, D, D, I, D, D, D, D, I.
- mem_ready low for 3 cycles with d_req pending.
  - Expect mem_req held high in IDLE with a stable mem_addr; acceptance on the 4th cycle.
- rst during WAIT_I, with mem_done arriving 2 cycles later.
  - Expect no if_ack; state IDLE.
  - A new if_req to 0x40 then completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_len,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, ERR_D} state_t;
  localparam logic [3:0] MAX = 4'(MAX_DATA_STREAK);
  localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};
  state_t r_state, w_next;
  logic [3:0] r_streak;
  logic w_gnt_d, w_gnt_i, w_bad, w_dok, w_take_d, w_take_i;
  logic [3:0] w_be;
  logic [31:0] w_wdata;
  assign w_gnt_d = d_req && !(if_req && r_streak == MAX);
  assign w_gnt_i = !w_gnt_d && if_req;
  assign w_bad = d_len == 2'b11 || (d_len == 2'b01 && d_addr[0]) ||
                 (d_len == 2'b10 && d_addr[1:0] != 2'b00);
  assign w_dok = w_gnt_d && !w_bad;
  assign w_be = d_len == 2'b00 ? 4'b0001 << d_addr[1:0] :
                d_len == 2'b01 ? 4'b0011 << d_addr[1:0] : 4'b1111;
  assign w_wdata = d_len == 2'b00 ? {4{d_wdata[7:0]}} :
                   d_len == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
  // illegal data accesses are granted without waiting for the memory
  assign w_take_d = r_state == IDLE && w_gnt_d && (w_bad || mem_ready);
  assign w_take_i = r_state == IDLE && w_gnt_i && mem_ready;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) r_streak <= '0;
    else if (!if_req || w_take_i) r_streak <= '0;
    else if (w_take_d && r_streak != MAX) r_streak <= r_streak + 4'd1;
  end
  always_comb begin
    w_next = r_state;
    if_ack = 1'b0;
    if_rdata = '0;
    d_ack = 1'b0;
    d_err = 1'b0;
    d_rdata = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_be = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        mem_req = w_dok || w_gnt_i;
        mem_we = w_dok && d_we;
        mem_addr = w_dok ? d_addr & ALIGN : w_gnt_i ? if_addr & ALIGN : '0;
        mem_be = w_dok ? w_be : w_gnt_i ? 4'hF : 4'h0;
        mem_wdata = w_dok ? w_wdata : '0;
        w_next = w_take_d ? (w_bad ? ERR_D : WAIT_D) : w_take_i ? WAIT_I : IDLE;
      end
      WAIT_I: begin
        if_ack = mem_done;
        if_rdata = mem_done ? mem_rdata : '0;
        w_next = mem_done ? IDLE : WAIT_I;
      end
      WAIT_D: begin
        d_ack = mem_done;
        d_rdata = mem_done ? mem_rdata : '0;
        w_next = mem_done ? IDLE : WAIT_D;
      end
      default: begin
        d_ack = 1'b1;
        d_err = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
endmodule
